// File: rtl/lut_neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_neuron_pkg
//  Description : Shared types and sizing helpers for the LUT neuron array.
//                Holds the LOAD/RUN/DRAIN state encoding and the functions
//                that derive the table address width and the neuron-select
//                width from the array parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package lut_neuron_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // One table entry per combination of all neuron inputs.
   function automatic int calc_addr_w(input int fan_in, input int in_bits);
      return fan_in * in_bits;
   endfunction

   // A single-neuron array still needs a 1-bit select so the port exists.
   function automatic int calc_nid_w(input int n_neurons);
      return (n_neurons <= 1) ? 1 : $clog2(n_neurons);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lut_neuron_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lut_neuron_ram
//  Description : Truth-table storage for one neuron. 2**ADDR_W x OUT_BITS,
//                one write port, one synchronous read port. The read
//                register doubles as the output stage of the array pipeline,
//                so it is reset and only updates when re_i is high.
//  Ports       : clk, rst_n          clock / async active-low reset
//                we_i, waddr_i,      table write
//                wdata_i
//                re_i, raddr_i       read enable / address
//                rdata_o             registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_neuron_ram #(
   parameter int ADDR_W   = 8,
   parameter int OUT_BITS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   waddr_i,
   input  logic [OUT_BITS-1:0] wdata_i,
   input  logic                re_i,
   input  logic [ADDR_W-1:0]   raddr_i,
   output logic [OUT_BITS-1:0] rdata_o
);

   (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem_q [2**ADDR_W];

   // Table contents are deliberately not reset; they are reloaded by software.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_o <= '0;
      end else if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/lut_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : lut_neuron_array
//  Description : Array of N_NEURONS LUT neurons behind a 2-stage valid/ready
//                pipeline. Stage 1 registers the input addresses, stage 2 is
//                the synchronous table read. A LOAD/RUN/DRAIN FSM only allows
//                table writes in LOAD and only accepts traffic in RUN.
//  Ports       : clk, rst_n                    clock / async active-low reset
//                cfg_we_i, cfg_nid_i,          table write (LOAD only)
//                cfg_addr_i, cfg_data_i
//                cfg_commit_i, cfg_unlock_i    LOAD->RUN / RUN->DRAIN pulses
//                cfg_ready_o                   high while in LOAD
//                s_valid_i, s_ready_o, s_data_i input stream (addresses)
//                m_valid_o, m_ready_i, m_data_o output stream (results)
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_neuron_array
   import lut_neuron_pkg::*;
#(
   parameter  int N_NEURONS = 4,
   parameter  int FAN_IN    = 4,
   parameter  int IN_BITS   = 2,
   parameter  int OUT_BITS  = 2,
   localparam int ADDR_W    = calc_addr_w(FAN_IN, IN_BITS),
   localparam int NID_W     = calc_nid_w(N_NEURONS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_we_i,
   input  logic [NID_W-1:0]              cfg_nid_i,
   input  logic [ADDR_W-1:0]             cfg_addr_i,
   input  logic [OUT_BITS-1:0]           cfg_data_i,
   input  logic                          cfg_commit_i,
   input  logic                          cfg_unlock_i,
   output logic                          cfg_ready_o,
   input  logic                          s_valid_i,
   output logic                          s_ready_o,
   input  logic [N_NEURONS*ADDR_W-1:0]   s_data_i,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic [N_NEURONS*OUT_BITS-1:0] m_data_o
);

   state_e                        state_q, state_d;
   logic                          v1_q, v1_d;
   logic                          v2_q, v2_d;
   logic [N_NEURONS*ADDR_W-1:0]   data1_q;
   logic                          en1, en2;
   logic                          accept;
   logic                          rd_en;
   logic [N_NEURONS-1:0]          tbl_we;

   // Stage 2 advances when empty or drained downstream; stage 1 when it can
   // hand its beat on. No s_valid term, so s_ready has no input->output path.
   assign en2         = !v2_q || m_ready_i;
   assign en1         = !v1_q || en2;
   assign s_ready_o   = (state_q == ST_RUN) && en1;
   assign accept      = s_valid_i && s_ready_o;
   assign cfg_ready_o = (state_q == ST_LOAD);
   assign m_valid_o   = v2_q;

   // Reading only for real beats keeps m_data stable while stalled.
   assign rd_en = en2 && v1_q;

   assign v1_d = en1 ? accept : v1_q;
   assign v2_d = en2 ? v1_q   : v2_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:  if (cfg_commit_i)    state_d = ST_RUN;
         ST_RUN:   if (cfg_unlock_i)    state_d = ST_DRAIN;
         ST_DRAIN: if (!v1_q && !v2_q)  state_d = ST_LOAD;
         default:                       state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         data1_q <= '0;
      end else begin
         state_q <= state_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         if (accept) begin
            data1_q <= s_data_i;
         end
      end
   end

   generate
      for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
         // Out-of-range neuron ids match no instance and are dropped.
         assign tbl_we[i] = cfg_we_i && (state_q == ST_LOAD) &&
                            (cfg_nid_i == NID_W'(i));

         lut_neuron_ram #(
            .ADDR_W   (ADDR_W),
            .OUT_BITS (OUT_BITS)
         ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (tbl_we[i]),
            .waddr_i (cfg_addr_i),
            .wdata_i (cfg_data_i),
            .re_i    (rd_en),
            .raddr_i (data1_q[i*ADDR_W +: ADDR_W]),
            .rdata_o (m_data_o[i*OUT_BITS +: OUT_BITS])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_neuron_array
//  Description : Self-checking bench for lut_neuron_array (3 neurons, so an
//                out-of-range neuron id is representable on cfg_nid).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_neuron_array;

   localparam int N   = 3;
   localparam int AW  = 8;
   localparam int OB  = 2;
   localparam int SDW = N * AW;
   localparam int MDW = N * OB;

   logic           clk;
   logic           rst_n;
   logic           cfg_we;
   logic [1:0]     cfg_nid;
   logic [AW-1:0]  cfg_addr;
   logic [OB-1:0]  cfg_data;
   logic           cfg_commit;
   logic           cfg_unlock;
   logic           cfg_ready;
   logic           s_valid;
   logic           s_ready;
   logic [SDW-1:0] s_data;
   logic           m_valid;
   logic           m_ready;
   logic [MDW-1:0] m_data;

   int checks   = 0;
   int failures = 0;
   int out_cnt  = 0;

   lut_neuron_array #(
      .N_NEURONS (N),
      .FAN_IN    (4),
      .IN_BITS   (2),
      .OUT_BITS  (OB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_we_i     (cfg_we),
      .cfg_nid_i    (cfg_nid),
      .cfg_addr_i   (cfg_addr),
      .cfg_data_i   (cfg_data),
      .cfg_commit_i (cfg_commit),
      .cfg_unlock_i (cfg_unlock),
      .cfg_ready_o  (cfg_ready),
      .s_valid_i    (s_valid),
      .s_ready_o    (s_ready),
      .s_data_i     (s_data),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_data_o     (m_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Beats in flight are a FIFO of expected results with an age in edges.
   // A beat is visible on the output once it is 2 edges old and at the head;
   // the stage holds at most 2 beats, a third only if the head leaves now.
   typedef struct {
      logic [MDW-1:0] exp;
      int             age;
   } item_t;

   item_t          mq[$];
   item_t          m_item;
   logic [OB-1:0]  mtbl [N][256];
   int             mstate = 0;   // 0 LOAD, 1 RUN, 2 DRAIN
   int             m_sz;
   bit             m_pop, m_acc;
   logic [MDW-1:0] m_e;
   bit             exp_mv, exp_sr;

   function automatic logic [OB-1:0] pat(input int n, input int a);
      return OB'((a & 3) ^ (n & 3));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mstate = 0;
      end else begin
         m_sz  = mq.size();
         m_pop = (m_sz > 0) && (mq[0].age >= 2) && m_ready;
         m_acc = (mstate == 1) && s_valid && ((m_sz < 2) || m_pop);
         for (int i = 0; i < N; i++) begin
            m_e[i*OB +: OB] = mtbl[i][s_data[i*AW +: AW]];
         end
         if (m_pop) void'(mq.pop_front());
         foreach (mq[k]) mq[k].age++;
         if (m_acc) begin
            m_item.exp = m_e;
            m_item.age = 1;
            mq.push_back(m_item);
         end
         if (mstate == 0 && cfg_we && cfg_nid < N) begin
            mtbl[cfg_nid][cfg_addr] = cfg_data;
         end
         case (mstate)
            0: if (cfg_commit) mstate = 1;
            1: if (cfg_unlock) mstate = 2;
            2: if (m_sz == 0)  mstate = 0;
            default: mstate = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         exp_mv = (mq.size() > 0) && (mq[0].age >= 2);
         exp_sr = (mstate == 1) && ((mq.size() < 2) || (exp_mv && m_ready));
         chk("cfg_ready", 32'(cfg_ready), 32'(mstate == 0));
         chk("s_ready",   32'(s_ready),   32'(exp_sr));
         chk("m_valid",   32'(m_valid),   32'(exp_mv));
         if (exp_mv) chk("m_data", 32'(m_data), 32'(mq[0].exp));
         if (m_valid && m_ready) out_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int nid, input int addr, input int data, input bit commit);
      cfg_we     = 1'b1;
      cfg_nid    = 2'(nid);
      cfg_addr   = AW'(addr);
      cfg_data   = OB'(data);
      cfg_commit = commit;
      step();
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
   endtask

   task automatic send_beat(input logic [SDW-1:0] d);
      bit got;
      got     = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = s_ready;
         step();
      end
      s_valid = 1'b0;
      chk("accept_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_mvalid();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = m_valid;
         if (!got) step();
      end
      chk("mvalid_timeout", 32'(got), 32'd1);
   endtask

   logic [SDW-1:0] beats [4];
   int             idx;
   int             base;
   bit             got_load;

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_nid = '0; cfg_addr = '0; cfg_data = '0;
      cfg_commit = 1'b0; cfg_unlock = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      #12;
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_s_ready",   32'(s_ready),   32'd0);
      chk("rst_m_valid",   32'(m_valid),   32'd0);
      chk("rst_m_data",    32'(m_data),    32'd0);
      #10 rst_n = 1'b1;
      step();

      // Test 1: full table load, two specific entries, commit, one lookup
      for (int n = 0; n < N; n++)
         for (int a = 0; a < 256; a++)
            cfg_write(n, a, pat(n, a), 1'b0);
      cfg_write(0, 8'hF0, 2'b10, 1'b0);
      cfg_write(1, 8'h33, 2'b01, 1'b1);
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = {8'h00, 8'h33, 8'hF0};
      @(negedge clk);
      chk("t1_s_ready", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b0;
      @(negedge clk);
      chk("t1_m_valid_early", 32'(m_valid), 32'd0);
      step();
      @(negedge clk);
      chk("t1_m_valid", 32'(m_valid), 32'd1);
      chk("t1_m_data",  32'(m_data),  32'b100110);
      repeat (3) step();

      // Test 2: backpressure, 4 beats offered with m_ready low
      base = out_cnt;
      for (int i = 0; i < 4; i++) beats[i] = SDW'($urandom);
      m_ready = 1'b0;
      idx = 0;
      s_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         s_data = beats[idx];
         @(negedge clk);
         if (s_ready) idx++;
         step();
      end
      chk("t2_accepted", 32'(idx), 32'd2);
      @(negedge clk);
      chk("t2_s_ready_stall", 32'(s_ready), 32'd0);
      step();
      m_ready = 1'b1;
      for (int c = 0; c < 10 && idx < 4; c++) begin
         s_data = beats[idx];
         @(negedge clk);
         if (s_ready) idx++;
         step();
      end
      s_valid = 1'b0;
      chk("t2_all_sent", 32'(idx), 32'd4);
      repeat (5) step();
      chk("t2_out_count", 32'(out_cnt - base), 32'd4);

      // Test 3: write in RUN is ignored
      cfg_we = 1'b1; cfg_nid = 2'd0; cfg_addr = 8'hF0; cfg_data = 2'b11;
      @(negedge clk);
      chk("t3_cfg_ready", 32'(cfg_ready), 32'd0);
      step();
      cfg_we = 1'b0;
      send_beat({8'h00, 8'h00, 8'hF0});
      wait_mvalid();
      chk("t3_lookup_f0", 32'(m_data[1:0]), 32'b10);
      repeat (3) step();

      // Test 4: unlock with two beats in flight
      base = out_cnt;
      send_beat({8'h01, 8'h02, 8'h03});
      send_beat({8'h04, 8'h05, 8'h06});
      cfg_unlock = 1'b1;
      step();
      cfg_unlock = 1'b0;
      s_valid = 1'b1;
      s_data  = {8'h07, 8'h08, 8'h09};
      @(negedge clk);
      chk("t4_s_ready_drain", 32'(s_ready), 32'd0);
      got_load = 1'b0;
      for (int c = 0; c < 10 && !got_load; c++) begin
         step();
         @(negedge clk);
         got_load = cfg_ready;
      end
      s_valid = 1'b0;
      chk("t4_back_to_load", 32'(got_load), 32'd1);
      chk("t4_out_count", 32'(out_cnt - base), 32'd2);
      step();

      // Test 6: out-of-range neuron id, then write together with commit
      cfg_write(N, 8'h00, 2'b11, 1'b0);
      cfg_write(0, 8'h00, 2'b01, 1'b1);
      @(negedge clk);
      chk("t6_run", 32'(cfg_ready), 32'd0);
      step();
      send_beat({8'h00, 8'h00, 8'h00});
      wait_mvalid();
      chk("t6_lookup_00", 32'(m_data), 32'b100101);
      step();

      // Test 5: asynchronous reset mid-stream
      m_ready = 1'b1;
      s_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         s_data = SDW'($urandom);
         step();
      end
      #3 rst_n = 1'b0;
      #1;
      chk("t5_m_valid_async", 32'(m_valid),   32'd0);
      chk("t5_s_ready_async", 32'(s_ready),   32'd0);
      chk("t5_cfg_ready",     32'(cfg_ready), 32'd1);
      s_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_post_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("t5_post_m_valid",   32'(m_valid),   32'd0);
      chk("t5_post_m_data",    32'(m_data),    32'd0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
